// File: rtl/btn_pkg.sv
// Shared constants for the button front-end: default timing parameters,
// channel indices and a small elaboration-time helper.
package btn_pkg;

  localparam int BTN_SYNC_STAGES_DEF   = 2;
  localparam int BTN_DEBOUNCE_DEF      = 16;
  localparam int BTN_REPEAT_DELAY_DEF  = 64;
  localparam int BTN_REPEAT_PERIOD_DEF = 16;

  localparam int BTN_HIT    = 0;
  localparam int BTN_STAND  = 1;
  localparam int BTN_DOUBLE = 2;
  localparam int BTN_START  = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: polarity fix, synchroniser, debounce counter and
// registered press/release pulses. Auto-repeat exists only with BTN_AUTOREPEAT_EN.
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = BTN_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic                   pin;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic                   lvl;
  logic                   flip;
  logic                   rpt_fire;

  // Inverting before the first flop keeps the whole chain in "1 = pressed" terms.
  assign pin  = ACTIVE_LOW ? ~raw : raw;
  assign s    = sync[SYNC_STAGES-1];
  assign flip = (s != lvl) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      lvl   <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      if (s == lvl) begin
        cnt <= '0;
      end else if (flip) begin
        cnt <= '0;
        lvl <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
      press <= en & ((flip & s) | rpt_fire);
      rel   <= en & flip & ~s;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;

  // rpt_cnt counts edges since the last press (real or repeated) while held.
  assign rpt_fire = lvl && !flip &&
                    (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST));

  always_ff @(posedge clk) begin
    if (rst || flip || !lvl) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  localparam bit REPEAT_CFG_OK = (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);
  assign rpt_fire = 1'b0 & REPEAT_CFG_OK;
`endif

  assign level = lvl;

endmodule

// File: rtl/btn_conditioner.sv
// N-channel button conditioner: independent channels plus an any_press summary.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = BTN_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised scoreboard bench for btn_conditioner with a sliding-window
// reference model of the debounce rule.
module tb_btn_conditioner;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RD   = 8;
  localparam int RP   = 3;
  localparam int W    = 3 * N + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic         any_press;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN          (N),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (1'b0),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: raw samples delayed SYNC edges, then the level flips once
  // the last DEB synchronised samples all disagree with it.
  logic [N-1:0] m_pipe[SYNC];
  logic [N-1:0] m_hist[DEB];
  logic [N-1:0] m_lvl;
  int           m_hold[N];

  task automatic model_clear();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = '0;
    for (int i = 0; i < DEB; i++) m_hist[i] = '0;
    for (int c = 0; c < N; c++) m_hold[c] = 0;
    m_lvl = '0;
  endtask

  task automatic step(input logic [N-1:0] raw, input logic e, input logic r);
    logic [N-1:0] nl, prs, rel;
    logic         differs;
    @(negedge clk);
    btn_raw = raw;
    en      = e;
    rst     = r;
    if (r) begin
      model_clear();
      exp_q.push_back('0);
    end else begin
      for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_pipe[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = raw;
      nl = m_lvl;
      for (int c = 0; c < N; c++) begin
        differs = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (m_hist[j][c] == m_lvl[c]) differs = 1'b0;
        if (differs) nl[c] = ~m_lvl[c];
      end
      prs = nl & ~m_lvl;
      rel = ~nl & m_lvl;
`ifdef BTN_AUTOREPEAT_EN
      for (int c = 0; c < N; c++) begin
        if (nl[c]) begin
          if (prs[c]) m_hold[c] = 0;
          else m_hold[c]++;
          if (m_hold[c] == RD || (m_hold[c] > RD && (m_hold[c] - RD) % RP == 0))
            prs[c] = 1'b1;
        end else begin
          m_hold[c] = 0;
        end
      end
`endif
      m_lvl = nl;
      if (!e) begin
        prs = '0;
        rel = '0;
      end
      exp_q.push_back({m_lvl, prs, rel, |prs});
    end
  endtask

  task automatic hold(input logic [N-1:0] raw, input logic e, input int n);
    for (int i = 0; i < n; i++) step(raw, e, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, so one expected entry per edge.
  initial begin
    logic [W-1:0] exp;
    logic [W-1:0] got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {btn_level, btn_press, btn_release, any_press};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got level=%b press=%b release=%b any=%b, expected level=%b press=%b release=%b any=%b",
                   cyc, got[W-1 -: N], got[2*N -: N], got[N -: N], got[0],
                   exp[W-1 -: N], exp[2*N -: N], exp[N -: N], exp[0]);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] cur;
    logic [N-1:0] drv;
    rst     = 1'b1;
    en      = 1'b0;
    btn_raw = '0;
    model_clear();

    repeat (3) step('0, 1'b1, 1'b1);

    // clean press on channel 0
    hold(4'b0001, 1'b1, 20);
    hold(4'b0000, 1'b1, 10);

    // bounce on channel 1
    hold(4'b0010, 1'b1, 3);
    hold(4'b0000, 1'b1, 1);
    hold(4'b0010, 1'b1, 3);
    hold(4'b0000, 1'b1, 10);

    // release while gated on channel 2
    hold(4'b0100, 1'b1, 10);
    hold(4'b0100, 1'b0, 3);
    hold(4'b0000, 1'b0, 10);
    hold(4'b0000, 1'b1, 5);

    // simultaneous press
    hold(4'b1001, 1'b1, 10);
    hold(4'b0000, 1'b1, 10);

    // reset mid-debounce on channel 3
    hold(4'b1000, 1'b1, 3);
    step(4'b1000, 1'b1, 1'b1);
    hold(4'b1000, 1'b1, 10);
    hold(4'b0000, 1'b1, 10);

    // long hold (auto-repeat when built with it)
    hold(4'b0001, 1'b1, 30);
    hold(4'b0000, 1'b1, 10);

    // random levels with occasional single-cycle glitches, gating and resets
    cur = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 19) == 0) cur[c] = ~cur[c];
      drv = cur;
      if ($urandom_range(0, 9) == 0) drv[$urandom_range(0, N-1)] ^= 1'b1;
      step(drv, ($urandom_range(0, 7) != 0), ($urandom_range(0, 299) == 0));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
